word16_result_checker: RTL

- Sequential response checker that sits at the consuming end of the 16-bit gate-level test interface.
- A stimulus side pushes expected 16-bit words into an internal FIFO.
- The DUT side delivers actual 16-bit results. The block pops one expected word per accepted result, compares the two, and keeps pass/fail counts plus a capture of the first mismatch.
- Used as a self-checking sink behind Or16/And16/Not16-class gates and later ALU blocks, so benches need no manual $display inspection.

---
 rtl/word16_result_checker.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/word16_result_checker.sv
// Self-checking sink: FIFO of expected 16-bit words compared against DUT results,
// with pass/fail counters and first-mismatch capture. Optional macro CHECKER_MASK_EN.
module word16_result_checker #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             exp_valid,
    output logic             exp_ready,
    input  logic [15:0]      exp_data,
    input  logic             exp_last,
`ifdef CHECKER_MASK_EN
    input  logic [15:0]      exp_mask,
`endif
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [15:0]      res_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] mm_index,
    output logic [15:0]      mm_expected,
    output logic [15:0]      mm_actual
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [AW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   pass_q, pass_d, fail_q, fail_d, idx_q, idx_d, mm_index_q, mm_index_d;
    logic               err_q, err_d;
    logic [15:0]        mm_exp_q, mm_exp_d, mm_act_q, mm_act_d;

    logic [15:0]        mem_data_q [DEPTH];
    logic               mem_last_q [DEPTH];
`ifdef CHECKER_MASK_EN
    logic [15:0]        mem_mask_q [DEPTH];
`endif

    logic        full, empty, push, pop, match;
    logic [15:0] head_data;
    logic        head_last;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign exp_ready = (state_q != IDLE) && !full;
    assign res_ready = (state_q == RUN) && !empty;
    // start discards any handshake offered in the same cycle
    assign push      = exp_valid && exp_ready && !start;
    assign pop       = res_valid && res_ready && !start;
    assign head_data = mem_data_q[rd_ptr_q[AW-1:0]];
    assign head_last = mem_last_q[rd_ptr_q[AW-1:0]];

`ifdef CHECKER_MASK_EN
    assign match = (((head_data ^ res_data) & mem_mask_q[rd_ptr_q[AW-1:0]]) == '0);
`else
    assign match = (head_data == res_data);
`endif

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        idx_d      = idx_q;
        err_d      = err_q;
        mm_index_d = mm_index_q;
        mm_exp_d   = mm_exp_q;
        mm_act_d   = mm_act_q;
        if (start) begin
            state_d    = RUN;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            pass_d     = '0;
            fail_d     = '0;
            idx_d      = '0;
            err_d      = 1'b0;
            mm_index_d = '0;
            mm_exp_d   = '0;
            mm_act_d   = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                idx_d    = sat_inc(idx_q);
                if (match) begin
                    pass_d = sat_inc(pass_q);
                end else begin
                    fail_d = sat_inc(fail_q);
                    err_d  = 1'b1;
                    if (!err_q) begin
                        mm_index_d = idx_q;
                        mm_exp_d   = head_data;
                        mm_act_d   = res_data;
                    end
                end
                if (head_last) state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            idx_q      <= '0;
            err_q      <= 1'b0;
            mm_index_q <= '0;
            mm_exp_q   <= '0;
            mm_act_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            mm_index_q <= mm_index_d;
            mm_exp_q   <= mm_exp_d;
            mm_act_q   <= mm_act_d;
        end
    end

    // Storage needs no reset: occupancy is defined solely by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q[AW-1:0]] <= exp_data;
            mem_last_q[wr_ptr_q[AW-1:0]] <= exp_last;
`ifdef CHECKER_MASK_EN
            mem_mask_q[wr_ptr_q[AW-1:0]] <= exp_mask;
`endif
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign err         = err_q;
    assign pass_cnt    = pass_q;
    assign fail_cnt    = fail_q;
    assign mm_index    = mm_index_q;
    assign mm_expected = mm_exp_q;
    assign mm_actual   = mm_act_q;

endmodule
